// File: rtl/bit_fetch_ctrl_if.sv
// Request/result handshake and FIFO head-word bus for the bit fetch controller.
interface bit_fetch_ctrl_if #(
  parameter int WWIDTH = 32,
  parameter int MAXLEN = 15
);
  localparam int LW = $clog2(MAXLEN + 1);

  logic              reqin;
  logic [LW-1:0]     reqlen;
  logic              ready;
  logic              pushout;
  logic [LW-1:0]     lenout;
  logic [MAXLEN-1:0] dataout;
  logic [WWIDTH-1:0] fifo_data;
  logic              fifo_empty_n;
  logic              fifo_pop_n;
  logic              fifo_clr_n;

  modport master (
    output reqin, reqlen, fifo_data, fifo_empty_n,
    input  ready, pushout, lenout, dataout, fifo_pop_n, fifo_clr_n
  );

  modport slave (
    input  reqin, reqlen, fifo_data, fifo_empty_n,
    output ready, pushout, lenout, dataout, fifo_pop_n, fifo_clr_n
  );
endinterface

// File: rtl/bit_fetch_ctrl.sv
// Refills a 2-word bit reservoir from a word FIFO and serves MSB-first
// variable-length bit requests, stalling in WAIT until enough bits arrive.
module bit_fetch_ctrl #(
  parameter int WWIDTH  = 32,
  parameter int MAXLEN  = 15,
  parameter int SCWIDTH = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              flush,
  bit_fetch_ctrl_if.slave                   bus,
  output logic [$clog2(2*WWIDTH+1)-1:0]     level,
  output logic [SCWIDTH-1:0]                stall_cycles
);
  localparam int RW = 2 * WWIDTH;
  localparam int CW = $clog2(RW + 1);
  localparam int LW = $clog2(MAXLEN + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [RW-1:0]     res;
  logic [LW-1:0]     len_q;
  logic              vld_p1;
  logic [LW-1:0]     len_p1;
  logic [MAXLEN-1:0] data_p1;

  logic              pop;
  logic              serve;
  logic              wait_go;
  logic [LW-1:0]     srv_len;
  logic [CW-1:0]     cnt_left;
  logic [RW-1:0]     res_shift;
  logic [RW-1:0]     word_aligned;
  logic [RW-1:0]     res_next;
  logic [CW-1:0]     cnt_next;

  function automatic logic [SCWIDTH-1:0] sat_inc(input logic [SCWIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Oldest n bits of the reservoir, right-aligned with zero upper bits.
  function automatic logic [MAXLEN-1:0] take_bits(input logic [RW-1:0] r,
                                                  input logic [LW-1:0] n);
    return r[RW-1 -: MAXLEN] >> (MAXLEN - int'(n));
  endfunction

  assign pop            = !reset && !flush && bus.fifo_empty_n && (cnt <= CW'(WWIDTH));
  assign bus.fifo_pop_n = !pop;
  assign bus.fifo_clr_n = reset || !flush;
  assign bus.ready      = (state == IDLE) && !reset && !flush;
  assign bus.pushout    = vld_p1;
  assign bus.lenout     = len_p1;
  assign bus.dataout    = data_p1;
  assign level          = cnt;

  always_comb begin
    serve   = 1'b0;
    wait_go = 1'b0;
    srv_len = '0;
    if (state == IDLE) begin
      if (bus.reqin && (bus.reqlen != '0)) begin
        if (CW'(bus.reqlen) <= cnt) begin
          serve   = 1'b1;
          srv_len = bus.reqlen;
        end else begin
          wait_go = 1'b1;
        end
      end
    end else if (CW'(len_q) <= cnt) begin
      serve   = 1'b1;
      srv_len = len_q;
    end
  end

  // A word popped in the same cycle as a serve lands just below the bits that remain.
  always_comb begin
    res_shift    = res << srv_len;
    cnt_left     = cnt - CW'(srv_len);
    word_aligned = {bus.fifo_data, {WWIDTH{1'b0}}} >> cnt_left;
    res_next     = pop ? (res_shift | word_aligned) : res_shift;
    cnt_next     = pop ? (cnt_left + CW'(WWIDTH)) : cnt_left;
  end

  // p1: registered result and reservoir update
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      res          <= '0;
      len_q        <= '0;
      stall_cycles <= '0;
      vld_p1       <= 1'b0;
      len_p1       <= '0;
      data_p1      <= '0;
    end else if (flush) begin
      state  <= IDLE;
      cnt    <= '0;
      res    <= '0;
      len_q  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      res    <= res_next;
      cnt    <= cnt_next;
      vld_p1 <= serve;
      if (serve) begin
        len_p1  <= srv_len;
        data_p1 <= take_bits(res, srv_len);
      end
      case (state)
        IDLE: begin
          if (wait_go) begin
            state <= WAIT;
            len_q <= bus.reqlen;
          end
        end
        WAIT: begin
          if (serve) begin
            state <= IDLE;
          end else begin
            stall_cycles <= sat_inc(stall_cycles);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bit_fetch_ctrl.sv
// Directed bench for bit_fetch_ctrl: a word-FIFO model feeds the DUT and a
// scoreboard queue holds expected results that a monitor process consumes.
module tb_bit_fetch_ctrl;
  logic        clock;
  logic        reset;
  logic        flush;
  logic [6:0]  level;
  logic [15:0] stall_cycles;

  bit_fetch_ctrl_if #(.WWIDTH(32), .MAXLEN(15)) bif ();

  bit_fetch_ctrl #(.WWIDTH(32), .MAXLEN(15), .SCWIDTH(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .bus          (bif),
    .level        (level),
    .stall_cycles (stall_cycles)
  );

  int checks   = 0;
  int failures = 0;
  logic [18:0] sb[$];
  logic [18:0] exp_v;
  int pops;

  logic [31:0] fmem [0:15];
  int rd = 0;
  int wr = 0;

  assign bif.fifo_data    = fmem[rd[3:0]];
  assign bif.fifo_empty_n = (rd != wr);

  always @(posedge clock) begin
    if (!bif.fifo_clr_n)     rd <= wr;
    else if (!bif.fifo_pop_n) rd <= rd + 1;
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    fmem[wr[3:0]] = w;
    wr = wr + 1;
  endtask

  task automatic wait_level(input int target, input int budget);
    int k = 0;
    while ((int'(level) != target) && (k < budget)) begin
      @(negedge clock); #1;
      k++;
    end
    chk("wait_level", 32'(level), 32'(target));
  endtask

  task automatic request(input logic [3:0] n, input logic [14:0] exp_data, input bit expect_out);
    int k = 0;
    bif.reqin  = 1'b1;
    bif.reqlen = n;
    #1;
    while (!bif.ready && (k < 20)) begin
      @(negedge clock); #1;
      k++;
    end
    chk("req_ready", 32'(bif.ready), 32'd1);
    if (expect_out) sb.push_back({n, exp_data});
    @(negedge clock);
    bif.reqin  = 1'b0;
    bif.reqlen = 4'd0;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bif.reqin  = 1'b0;
    bif.reqlen = 4'd0;

    fork
      forever begin
        @(negedge clock);
        if (bif.pushout) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pushout lenout=%0d dataout=%0h expected=none",
                     bif.lenout, bif.dataout);
          end else begin
            exp_v = sb.pop_front();
            chk("pushout_result", 32'({bif.lenout, bif.dataout}), 32'(exp_v));
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    chk("rst_ready", 32'(bif.ready), 32'd0);
    chk("rst_pushout", 32'(bif.pushout), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_pop_n", 32'(bif.fifo_pop_n), 32'd1);
    chk("rst_clr_n", 32'(bif.fifo_clr_n), 32'd1);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk("rst_outs", 32'({bif.lenout, bif.dataout}), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      chk("idle_level", 32'(level), 32'd0);
      chk("idle_pop_n", 32'(bif.fifo_pop_n), 32'd1);
      chk("idle_ready", 32'(bif.ready), 32'd1);
      chk("idle_stall", 32'(stall_cycles), 32'd0);
    end

    // Basic serve
    push_word(32'hA5C30F96);
    #1;
    chk("basic_pop_n", 32'(bif.fifo_pop_n), 32'd0);
    wait_level(32, 10);
    request(4'd4, 15'h000A, 1'b1);
    request(4'd15, 15'h2E18, 1'b1);
    #1;
    chk("basic_level", 32'(level), 32'd13);

    // Stall across a word boundary
    request(4'd15, 15'h3E5B, 1'b1);
    #1;
    chk("wait_ready", 32'(bif.ready), 32'd0);
    chk("wait_stall0", 32'(stall_cycles), 32'd0);
    repeat (3) @(negedge clock);
    #1;
    chk("wait_stall3", 32'(stall_cycles), 32'd3);
    push_word(32'hFFFF0000);
    #1;
    chk("wait_pop_n", 32'(bif.fifo_pop_n), 32'd0);
    @(negedge clock); #1;
    chk("wait_level45", 32'(level), 32'd45);
    chk("wait_stall4", 32'(stall_cycles), 32'd4);
    @(negedge clock); #1;
    chk("wait_level30", 32'(level), 32'd30);
    chk("wait_back_idle", 32'(bif.ready), 32'd1);
    chk("wait_stall_hold", 32'(stall_cycles), 32'd4);

    // Concurrent pop and serve
    request(4'd10, 15'h03FF, 1'b1);
    #1;
    chk("conc_level20", 32'(level), 32'd20);
    push_word(32'h12345678);
    push_word(32'h9ABCDEF0);
    #1;
    chk("conc_pop_n", 32'(bif.fifo_pop_n), 32'd0);
    request(4'd8, 15'h00F0, 1'b1);
    #1;
    chk("conc_level44", 32'(level), 32'd44);
    chk("conc_no_pop", 32'(bif.fifo_pop_n), 32'd1);
    request(4'd12, 15'h0000, 1'b1);
    #1;
    chk("conc_level32", 32'(level), 32'd32);
    chk("conc_pop2", 32'(bif.fifo_pop_n), 32'd0);
    @(negedge clock); #1;
    chk("conc_level64", 32'(level), 32'd64);

    // Refill and no-op guards
    flush = 1'b1;
    #1;
    chk("fl_clr_n", 32'(bif.fifo_clr_n), 32'd0);
    chk("fl_no_pop", 32'(bif.fifo_pop_n), 32'd1);
    @(negedge clock);
    flush = 1'b0;
    #1;
    chk("fl_level", 32'(level), 32'd0);
    chk("fl_clr_rel", 32'(bif.fifo_clr_n), 32'd1);
    chk("fl_stall_kept", 32'(stall_cycles), 32'd4);
    push_word(32'h11111111);
    push_word(32'h22222222);
    push_word(32'h33333333);
    push_word(32'h44444444);
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (!bif.fifo_pop_n) pops++;
      @(negedge clock);
    end
    #1;
    chk("refill_pops", 32'(pops), 32'd2);
    chk("refill_level", 32'(level), 32'd64);
    chk("refill_pop_n", 32'(bif.fifo_pop_n), 32'd1);
    request(4'd0, 15'h0000, 1'b0);
    #1;
    chk("noop_pushout", 32'(bif.pushout), 32'd0);
    request(4'd15, 15'h0888, 1'b1);
    #1;
    chk("refill_level49", 32'(level), 32'd49);

    // Flush during WAIT
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    #1;
    chk("fw_level0", 32'(level), 32'd0);
    request(4'd5, 15'h0000, 1'b0);
    #1;
    chk("fw_in_wait", 32'(bif.ready), 32'd0);
    flush = 1'b1;
    #1;
    chk("fw_clr_n", 32'(bif.fifo_clr_n), 32'd0);
    @(negedge clock);
    flush = 1'b0;
    #1;
    chk("fw_level", 32'(level), 32'd0);
    chk("fw_idle", 32'(bif.ready), 32'd1);
    chk("fw_stall", 32'(stall_cycles), 32'd4);
    repeat (3) @(negedge clock);
    #1;
    chk("fw_hold_outs", 32'({bif.lenout, bif.dataout}), 32'({4'd15, 15'h0888}));

    // Reset during a serve cycle
    push_word(32'hDEADBEEF);
    wait_level(32, 10);
    bif.reqin  = 1'b1;
    bif.reqlen = 4'd8;
    #1;
    chk("rs_ready", 32'(bif.ready), 32'd1);
    sb.push_back({4'd8, 15'h00DE});
    @(negedge clock);
    bif.reqin  = 1'b0;
    bif.reqlen = 4'd0;
    reset = 1'b1;
    #1;
    chk("rs_ready_low", 32'(bif.ready), 32'd0);
    chk("rs_pop_n", 32'(bif.fifo_pop_n), 32'd1);
    @(negedge clock); #1;
    chk("rs_pushout", 32'(bif.pushout), 32'd0);
    chk("rs_outs", 32'({bif.lenout, bif.dataout}), 32'd0);
    chk("rs_level", 32'(level), 32'd0);
    chk("rs_stall", 32'(stall_cycles), 32'd0);
    chk("rs_clr_n", 32'(bif.fifo_clr_n), 32'd1);
    reset = 1'b0;
    #1;
    chk("rs_ready_rel", 32'(bif.ready), 32'd1);

    repeat (3) @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bit_fetch_ctrl.md
Name: bit_fetch_ctrl

Overview:
- Sits between the 32-bit word FIFO and a variable-length bit consumer.
- Sequences FIFO reads through the FIFO's active-low pop/clear strobes into a 64-bit bit reservoir.
- Serves requests of 1..15 bits, MSB-first, and reports fill level and stall statistics for the bitstream path.

Parameters:
- WWIDTH, 32, FIFO word width (reservoir = 2*WWIDTH bits)
- MAXLEN, 15, maximum request length in bits (dataout width)
- SCWIDTH, 16, stall counter width

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous discard of reservoir and pending request
- reqin  in  1  bit request strobe
- reqlen  in  4  requested bit count, 1..15; 0 = no-op
- ready  out  1  request accepted this cycle if reqin=1
- pushout  out  1  one-cycle result valid
- lenout  out  4  length of the delivered result
- dataout  out  15  result bits, right-aligned, upper bits zero
- fifo_data  in  32  FIFO head word (combinational read)
- fifo_empty_n  in  1  1 = FIFO holds at least one word
- fifo_pop_n  out  1  active-low FIFO read strobe
- fifo_clr_n  out  1  active-low FIFO clear strobe
- level  out  7  valid bits in reservoir, 0..64
- stall_cycles  out  16  saturating count of cycles spent in WAIT

Behaviour:
- Reset is synchronous and active-high. On reset:
  - state=IDLE; cnt=0; reservoir=0; stall_cycles=0.
  - pushout=0; lenout=0; dataout=0.
  - fifo_pop_n=1; fifo_clr_n=1.
  - ready=0 while reset is high.
- Reservoir ordering:
  - Bit 63 is the oldest bit.
  - An appended word lands at positions [63-cnt : 32-cnt].
  - Word bit 31 is consumed first.
- Refill (combinational):
  - fifo_pop_n=0 iff !reset && !flush && fifo_empty_n && cnt<=32.
  - fifo_data is captured on the same edge, and cnt increments by 32.
  - At most one pop per cycle.
- ready = (state==IDLE) && !reset && !flush.
- FSM states IDLE, WAIT:
  - IDLE, reqin=1, reqlen=0: ignored, no pushout.
  - IDLE, reqin=1, 1<=reqlen<=cnt: serve; stay IDLE.
  - IDLE, reqin=1, reqlen>cnt: latch len; go to WAIT.
  - WAIT: if len<=cnt, serve and go to IDLE; otherwise stall_cycles++ (saturate at 0xFFFF).
  - reqin while ready=0 is ignored. The requester holds its request until it sees ready.
- Serve:
  - On the next edge: pushout=1 for exactly one cycle, lenout=len, dataout=reservoir[63:64-len].
  - Then the reservoir is shifted left by len and cnt decreases by len.
  - Latency is 1 cycle from an accepted reqin when bits are already available.
- Simultaneous serve and pop in one cycle:
  - Data is taken from the pre-shift reservoir.
  - The new word lands at [63-(cnt-len) : 32-(cnt-len)].
  - cnt_next = cnt - len + 32, which never exceeds 64.
- Outputs when not serving: pushout=0; lenout and dataout hold their last values.
- flush (priority below reset, above all else):
  - Clears cnt, reservoir and pending len; state=IDLE.
  - fifo_clr_n=0 for that cycle; no pop.
  - stall_cycles is retained.
  - A pushout already scheduled for this edge is suppressed.
- Reset or flush during WAIT drops the pending request with no pushout.
- The FIFO's own full/empty handling is trusted; the controller never pops while fifo_empty_n=0.

Test Plan:
- Reset, then idle 5 cycles:
  - pushout=0, level=0, fifo_pop_n=1, ready=1.
  - stall_cycles stays 0 while no request is pending.
- Basic serve:
  - Setup: FIFO holds 0xA5C30F96; wait until level=32.
  - reqlen=4 -> next cycle pushout=1, lenout=4, dataout=0x000A.
  - Then reqlen=15 -> dataout=0x2E18, level=13.
- Stall across a word boundary:
  - Setup: FIFO empty, level=13.
  - reqlen=15 -> ready=0, WAIT, stall_cycles increments each cycle.
  - Push 0xFFFF0000 -> pop, then pushout with dataout=0x3E5B, lenout=15, level=30, back in IDLE.
- Concurrent pop and serve:
  - Setup: level=20, FIFO non-empty.
  - reqlen=8 -> pop and serve on the same edge, level=44, delivered bits are the oldest 8.
  - A second pop occurs only once level<=32.
- Refill and no-op guards:
  - Stream 4 words with no requests -> exactly 2 pops, level=64.
  - fifo_pop_n stays 1 while level>32.
  - reqlen=0 -> no pushout.
- Flush and reset mid-operation:
  - Flush during WAIT -> fifo_clr_n=0 for one cycle, level=0, no pushout, IDLE.
  - Reset asserted during a serve cycle -> pushout=0 and all outputs return to their reset values.
